multiplier_bus_driver: RTL

//  Bus initiator for the Multiplier slave register interface: accepts one 64x64 job from a local client,

---
 rtl/mul_bus_pkg.sv | 64 ++++++
 rtl/mul_bus_rd_pipe.sv | 42 ++++
 rtl/multiplier_bus_driver.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_bus_pkg.sv
// rtl/mul_bus_pkg.sv - register map, state encoding and helpers shared by the multiplier bus driver
package mul_bus_pkg;

    // Multiplier slave register map (word addresses)
    localparam logic [7:0] ADDR_MCAND_LO  = 8'h00;
    localparam logic [7:0] ADDR_MCAND_HI  = 8'h01;
    localparam logic [7:0] ADDR_MPLIER_LO = 8'h02;
    localparam logic [7:0] ADDR_MPLIER_HI = 8'h03;
    localparam logic [7:0] ADDR_OPSTART   = 8'h04;
    localparam logic [7:0] ADDR_OPCLEAR   = 8'h05;
    localparam logic [7:0] ADDR_INTR_EN   = 8'h06;
    localparam logic [7:0] ADDR_STATUS    = 8'h07;
    localparam logic [7:0] ADDR_RESULT0   = 8'h08;
    localparam logic [7:0] ADDR_RESULT1   = 8'h09;
    localparam logic [7:0] ADDR_RESULT2   = 8'h0A;
    localparam logic [7:0] ADDR_RESULT3   = 8'h0B;

    localparam int RESULT_WORDS  = 4;
    localparam int OPERAND_WORDS = 4;

    // Driver FSM encoding
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_CLR0     = 4'd1;
    localparam logic [3:0] ST_INTEN    = 4'd2;
    localparam logic [3:0] ST_WR_OP    = 4'd3;
    localparam logic [3:0] ST_START    = 4'd4;
    localparam logic [3:0] ST_WAIT_INT = 4'd5;
    localparam logic [3:0] ST_RD_RES   = 4'd6;
    localparam logic [3:0] ST_CLR1     = 4'd7;
    localparam logic [3:0] ST_ABORT    = 4'd8;
    localparam logic [3:0] ST_DONE     = 4'd9;

    // Operand beat k goes to this register
    function automatic logic [7:0] operand_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    operand_addr = ADDR_MCAND_LO;
            2'd1:    operand_addr = ADDR_MCAND_HI;
            2'd2:    operand_addr = ADDR_MPLIER_LO;
            default: operand_addr = ADDR_MPLIER_HI;
        endcase
    endfunction

    // Operand beat k carries this 32-bit slice: A lo, A hi, B lo, B hi
    function automatic logic [31:0] operand_word(input logic [63:0] a, input logic [63:0] b,
                                                 input logic [1:0] idx);
        case (idx)
            2'd0:    operand_word = a[31:0];
            2'd1:    operand_word = a[63:32];
            2'd2:    operand_word = b[31:0];
            default: operand_word = b[63:32];
        endcase
    endfunction

    // Result word k lives at this register
    function automatic logic [7:0] result_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    result_addr = ADDR_RESULT0;
            2'd1:    result_addr = ADDR_RESULT1;
            2'd2:    result_addr = ADDR_RESULT2;
            default: result_addr = ADDR_RESULT3;
        endcase
    endfunction

endpackage

// File: rtl/mul_bus_rd_pipe.sv
// rtl/mul_bus_rd_pipe.sv - RD_LAT-deep {valid,word_idx} shift aligning read-data captures to read issues
module mul_bus_rd_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [1:0] in_idx,
    output logic       out_valid,
    output logic [1:0] out_idx
);

    logic [RD_LAT-1:0]      vld_q, vld_d;
    logic [RD_LAT-1:0][1:0] idx_q, idx_d;

    // Shift each issued read one stage per cycle; the last stage marks the cycle its data is on S_dout
    always_comb begin
        vld_d    = '0;
        idx_d    = '0;
        vld_d[0] = in_valid;
        idx_d[0] = in_idx;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
    end

    // Pipeline registers, flushed by reset so no stale capture survives an abort
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_idx   = idx_q[RD_LAT-1];

endmodule

// File: rtl/multiplier_bus_driver.sv
// rtl/multiplier_bus_driver.sv - bus initiator running one 64x64 job through the Multiplier slave registers
module multiplier_bus_driver
    import mul_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RD_LAT         = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [63:0]  req_multiplicand,
    input  logic [63:0]  req_multiplier,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_result,
    output logic         resp_error,
    output logic         busy,
    output logic         S_sel,
    output logic         S_wr,
    output logic [7:0]   S_address,
    output logic [31:0]  S_din,
    input  logic [31:0]  S_dout,
    input  logic         m_interrupt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [3:0]                    state_q, state_d;
    logic [2:0]                    beat_q, beat_d;
    logic [TW-1:0]                 tmo_q, tmo_d;
    logic [63:0]                   mcand_q, mcand_d;
    logic [63:0]                   mplier_q, mplier_d;
    logic [RESULT_WORDS-1:0][31:0] result_q, result_d;
    logic                          error_q, error_d;
    logic                          resp_valid_q, resp_valid_d;
    logic                          req_ready_q, req_ready_d;
    logic                          busy_q, busy_d;
    logic                          sel_q, sel_d;
    logic                          wr_q, wr_d;
    logic [7:0]                    addr_q, addr_d;
    logic [31:0]                   din_q, din_d;
    logic                          cap_valid;
    logic [1:0]                    cap_idx;

    // Reads on the bus are tracked so each S_dout sample lands in the right result word
    mul_bus_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (sel_q & ~wr_q),
        .in_idx    (addr_q[1:0]),
        .out_valid (cap_valid),
        .out_idx   (cap_idx)
    );

    // Next-state, beat/timeout counters, operand capture and result assembly
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        tmo_d    = tmo_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        error_d  = error_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    mcand_d  = req_multiplicand;
                    mplier_d = req_multiplier;
                    result_d = '0;
                    error_d  = 1'b0;
                    state_d  = ST_CLR0;
                end
            end
            ST_CLR0:  state_d = ST_INTEN;
            ST_INTEN: begin
                beat_d  = 3'd0;
                state_d = ST_WR_OP;
            end
            ST_WR_OP: begin
                if (beat_q == 3'(OPERAND_WORDS - 1)) begin
                    state_d = ST_START;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            ST_START: begin
                tmo_d   = '0;
                state_d = ST_WAIT_INT;
            end
            ST_WAIT_INT: begin
                // Interrupt is checked first so it wins over the terminal count
                if (m_interrupt) begin
                    beat_d  = 3'd0;
                    state_d = ST_RD_RES;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_ABORT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_RD_RES: begin
                if (beat_q != 3'(RESULT_WORDS)) begin
                    beat_d = beat_q + 3'd1;
                end
                if (cap_valid) begin
                    result_d[cap_idx] = S_dout;
                    if (cap_idx == 2'(RESULT_WORDS - 1)) begin
                        state_d = ST_CLR1;
                    end
                end
            end
            ST_CLR1:  state_d = ST_DONE;
            ST_ABORT: begin
                error_d  = 1'b1;
                result_d = '0;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bus beat and client handshake outputs are decoded from the upcoming state so they come straight off flops
    always_comb begin
        sel_d        = 1'b0;
        wr_d         = 1'b0;
        addr_d       = 8'h00;
        din_d        = 32'h0;
        req_ready_d  = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        resp_valid_d = (state_d == ST_DONE);
        case (state_d)
            ST_CLR0, ST_CLR1, ST_ABORT: begin
                sel_d  = 1'b1;
                wr_d   = 1'b1;
                addr_d = ADDR_OPCLEAR;
                din_d  = 32'd1;
            end
            ST_INTEN: begin
                sel_d  = 1'b1;
                wr_d   = 1'b1;
                addr_d = ADDR_INTR_EN;
                din_d  = 32'd1;
            end
            ST_WR_OP: begin
                sel_d  = 1'b1;
                wr_d   = 1'b1;
                addr_d = operand_addr(beat_d[1:0]);
                din_d  = operand_word(mcand_q, mplier_q, beat_d[1:0]);
            end
            ST_START: begin
                sel_d  = 1'b1;
                wr_d   = 1'b1;
                addr_d = ADDR_OPSTART;
                din_d  = 32'd1;
            end
            ST_RD_RES: begin
                if (beat_d < 3'(RESULT_WORDS)) begin
                    sel_d  = 1'b1;
                    addr_d = result_addr(beat_d[1:0]);
                end
            end
            default: ;
        endcase
    end

    // State, counters, data registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            tmo_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            result_q     <= '0;
            error_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            sel_q        <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            tmo_q        <= tmo_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            result_q     <= result_d;
            error_q      <= error_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            sel_q        <= sel_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign busy        = busy_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = result_q;
    assign resp_error  = error_q;
    assign S_sel       = sel_q;
    assign S_wr        = wr_q;
    assign S_address   = addr_q;
    assign S_din       = din_q;

endmodule
